// File: rtl/spi_ram_ctrl_p_if.sv
// SPI-side frame/response bundle for spi_ram_ctrl_p.
// master = SPI slave front end, slave = RAM controller.
interface spi_ram_ctrl_p_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              tx_ack;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              rd_drop;

  modport master (
    output din, rx_valid, tx_ack,
    input  dout, tx_valid, rd_drop
  );

  modport slave (
    input  din, rx_valid, tx_ack,
    output dout, tx_valid, rd_drop
  );
endinterface

// File: rtl/spi_ram_ctrl_p.sv
// Command-decoded single-port RAM behind the SPI slave; read data held on tx_valid until tx_ack.
// Optional SPI_RAM_AUTO_INC_EN: post-increment wr_addr/rd_addr for burst transfers.
module spi_ram_ctrl_p #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_ram_ctrl_p_if.slave   bus
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic              cmd_wa, cmd_wr, cmd_ra, cmd_rd;
  logic              rd_accept, rd_drop_nxt;
  logic              wr_in_range, rd_in_range;

  assign cmd     = bus.din[DATA_W+1:DATA_W];
  assign payload = bus.din[DATA_W-1:0];

  always_comb begin
    cmd_wa      = bus.rx_valid && (cmd == 2'b00);
    cmd_wr      = bus.rx_valid && (cmd == 2'b01);
    cmd_ra      = bus.rx_valid && (cmd == 2'b10);
    cmd_rd      = bus.rx_valid && (cmd == 2'b11);
    wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  end

`ifdef SPI_RAM_AUTO_INC_EN
  // Wrap at MEM_DEPTH; out-of-range addresses fall through the natural 2**ADDR_W wrap.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] s;
    s = {1'b0, a} + {{ADDR_W{1'b0}}, 1'b1};
    return (s == DEPTH_L) ? '0 : s[ADDR_W-1:0];
  endfunction
`endif

  always_comb begin
    state_nxt   = state;
    rd_accept   = 1'b0;
    rd_drop_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_rd) begin
          rd_accept = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        rd_drop_nxt = cmd_rd;
        state_nxt   = HOLD;
      end
      HOLD: begin
        rd_drop_nxt = cmd_rd;
        if (bus.tx_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && cmd_wr && wr_in_range) mem[wr_addr] <= payload;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.dout     <= '0;
      bus.tx_valid <= 1'b0;
      bus.rd_drop  <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      rd_word      <= '0;
    end else begin
      bus.rd_drop <= rd_drop_nxt;

      // Captured at acceptance so a write during FETCH cannot alter the returned word.
      if (rd_accept) rd_word <= rd_in_range ? mem[rd_addr] : '0;

      if (state == FETCH) begin
        bus.dout     <= rd_word;
        bus.tx_valid <= 1'b1;
      end else if ((state == HOLD) && bus.tx_ack) begin
        bus.tx_valid <= 1'b0;
      end

      if (cmd_wa) wr_addr <= payload[ADDR_W-1:0];
`ifdef SPI_RAM_AUTO_INC_EN
      else if (cmd_wr) wr_addr <= addr_inc(wr_addr);
`endif

      if (cmd_ra) rd_addr <= payload[ADDR_W-1:0];
`ifdef SPI_RAM_AUTO_INC_EN
      else if (rd_accept) rd_addr <= addr_inc(rd_addr);
`endif
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl_p.sv
// Scoreboard bench for spi_ram_ctrl_p (DATA_W=8, ADDR_W=8, MEM_DEPTH=200).
module tb_spi_ram_ctrl_p;

  localparam int DEPTH = 200;
`ifdef SPI_RAM_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk;
  logic rst_n;

  spi_ram_ctrl_p_if #(.DATA_W(8)) bus ();

  spi_ram_ctrl_p #(
    .DATA_W   (8),
    .ADDR_W   (8),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] mem_m [256];
  int         wa_m = 0;
  int         ra_m = 0;
  logic [7:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int inc(input int a);
    int s;
    s = (a + 1) % 256;
    return (s == DEPTH) ? 0 : s;
  endfunction

  task automatic model(input logic [1:0] c, input logic [7:0] p);
    case (c)
      2'b00: wa_m = p;
      2'b01: begin
        if (wa_m < DEPTH) mem_m[wa_m] = p;
        if (AUTO) wa_m = inc(wa_m);
      end
      2'b10: ra_m = p;
      default: begin
        exp_q.push_back((ra_m < DEPTH) ? mem_m[ra_m] : 8'h00);
        if (AUTO) ra_m = inc(ra_m);
      end
    endcase
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] p);
    bus.din      = {c, p};
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    model(c, p);
  endtask

  // Issue a read, optionally write in FETCH and/or send a dropped read during HOLD.
  task automatic rd_req(input int hold_cyc, input int drop_at,
                        input bit fetch_wr, input logic [7:0] fw_val);
    int         lat;
    logic [7:0] exp_w;
    exp_w = 8'h00;
    send(2'b11, 8'h00);
    chk("fetch_txv", {31'd0, bus.tx_valid}, 0);
    if (fetch_wr) begin
      bus.din      = {2'b01, fw_val};
      bus.rx_valid = 1'b1;
    end
    lat = 0;
    while (!bus.tx_valid && lat < 5) begin
      @(posedge clk); #1;
      if (fetch_wr && lat == 0) begin
        bus.rx_valid = 1'b0;
        model(2'b01, fw_val);
      end
      lat++;
    end
    chk("rd_lat", lat, 1);
    chk("q_size", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      chk("rd_dat", {24'd0, bus.dout}, {24'd0, exp_w});
    end
    for (int i = 0; i < hold_cyc; i++) begin
      if (i == drop_at) begin
        bus.din      = {2'b11, 8'hFF};
        bus.rx_valid = 1'b1;
      end
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      chk("hold_txv", {31'd0, bus.tx_valid}, 1);
      chk("hold_dout", {24'd0, bus.dout}, {24'd0, exp_w});
      chk("rd_drop", {31'd0, bus.rd_drop}, (i == drop_at) ? 1 : 0);
    end
    bus.tx_ack = 1'b1;
    @(posedge clk); #1;
    bus.tx_ack = 1'b0;
    chk("ack_txv", {31'd0, bus.tx_valid}, 0);
    chk("ack_dout", {24'd0, bus.dout}, {24'd0, exp_w});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n        = 1'b0;
    bus.din      = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", {24'd0, bus.dout}, 0);
    chk("rst_txv", {31'd0, bus.tx_valid}, 0);
    chk("rst_drop", {31'd0, bus.rd_drop}, 0);
    rst_n = 1'b1;

    // Basic write/read with immediate ack.
    send(2'b00, 8'h10);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h10);
    rd_req(0, -1, 1'b0, 8'h00);

    // Long hold with a dropped read mid-way; rd_addr must be unaffected.
    send(2'b10, 8'h10);
    rd_req(10, 4, 1'b0, 8'h00);
    send(2'b10, 8'h10);
    rd_req(1, 0, 1'b0, 8'h00);

    // Seed address 1 so a read after the auto-inc wrap has a known value.
    send(2'b00, 8'h01);
    send(2'b01, 8'h77);

    // Burst across the MEM_DEPTH wrap.
    send(2'b00, 8'(DEPTH - 2));
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b01, 8'h33);
    send(2'b10, 8'(DEPTH - 2));
    rd_req(0, -1, 1'b0, 8'h00);
    rd_req(0, -1, 1'b0, 8'h00);
    rd_req(0, -1, 1'b0, 8'h00);
    rd_req(0, -1, 1'b0, 8'h00);

    // Out-of-range write discarded, read returns zero; last legal address works.
    send(2'b00, 8'(DEPTH));
    send(2'b01, 8'h5A);
    send(2'b10, 8'(DEPTH));
    rd_req(0, -1, 1'b0, 8'h00);
    send(2'b10, 8'hFF);
    rd_req(0, -1, 1'b0, 8'h00);
    send(2'b00, 8'(DEPTH - 1));
    send(2'b01, 8'hC7);
    send(2'b10, 8'(DEPTH - 1));
    rd_req(0, -1, 1'b0, 8'h00);

    // Write during FETCH does not alter the captured word.
    send(2'b00, 8'h03);
    send(2'b01, 8'h01);
    send(2'b10, 8'h03);
    send(2'b00, 8'h03);
    rd_req(0, -1, 1'b1, 8'h02);
    send(2'b10, 8'h03);
    rd_req(2, -1, 1'b0, 8'h00);

    // Reset during HOLD aborts the transaction.
    send(2'b10, 8'h10);
    send(2'b11, 8'h00);
    @(posedge clk); #1;
    chk("pre_rst_txv", {31'd0, bus.tx_valid}, 1);
    chk("pre_rst_q", exp_q.size(), 1);
    if (exp_q.size() > 0) chk("pre_rst_dout", {24'd0, bus.dout}, {24'd0, exp_q.pop_front()});
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wa_m  = 0;
    ra_m  = 0;
    chk("hrst_txv", {31'd0, bus.tx_valid}, 0);
    chk("hrst_dout", {24'd0, bus.dout}, 0);
    chk("hrst_drop", {31'd0, bus.rd_drop}, 0);
    @(posedge clk); #1;
    chk("hrst_idle_txv", {31'd0, bus.tx_valid}, 0);
    send(2'b10, 8'h10);
    rd_req(1, -1, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
